// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - req/ack bus carrying the fetch and data ports of mem_arb
interface mem_arb_if #(
    parameter int AW = 8,
    parameter int DW = 32
) ();
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_ack;
    logic [DW-1:0]   if_rdata;

    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_ack;
    logic [DW-1:0]   d_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  if_ack, if_rdata, d_ack, d_rdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output if_ack, if_rdata, d_ack, d_rdata
    );
endinterface

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - shared single-port RAM with round-robin fetch/data arbiter
module mem_arb #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_arb_if.slave        bus,
    input  logic [AW-1:0]   dbg_addr,
    output logic [DW-1:0]   dbg_rdata,
    output logic            busy,
    output logic [15:0]     cnt_if,
    output logic [15:0]     cnt_d
);
    localparam int NB = DW / 8;
    localparam logic [1:0] LAT_MAX = 2'(RD_LAT - 1);
    localparam logic [AW:0] LIMIT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t        state, state_n;
    logic          take, take_d;
    logic          last_d, gnt_d;
    logic [1:0]    lat_cnt;
    logic [AW-1:0] ram_addr, sel_addr;
    logic          ram_ok, wr_en;
    logic [DW-1:0] rd_word, rd_final;
    logic [DW-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    // Tie goes to whoever was not granted last; last_d resets to fetch.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        take_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    take    = 1'b1;
                    take_d  = bus.d_req && (!bus.if_req || !last_d);
                    state_n = (take_d && bus.d_we) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT:  if (lat_cnt == LAT_MAX) state_n = S_ACK;
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign sel_addr   = take_d ? bus.d_addr : bus.if_addr;
    assign wr_en      = take_d && bus.d_we && in_range(bus.d_addr);
    assign rd_word    = ram_ok ? mem[ram_addr] : '0;
    assign bus.if_ack = (state == S_ACK) && !gnt_d;
    assign bus.d_ack  = (state == S_ACK) && gnt_d;
    assign busy       = (state != S_IDLE);

    // Writes commit on the grant edge; rst on that edge suppresses them.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.d_be[i]) mem[bus.d_addr][i*8 +: 8] <= bus.d_wdata[i*8 +: 8];
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign rd_final = rd_word;
        end else begin : g_pipe
            logic [DW-1:0] pipe [RD_LAT-1];
            always_ff @(posedge clk) begin
                pipe[0] <= rd_word;
                for (int i = 1; i < RD_LAT - 1; i++) pipe[i] <= pipe[i-1];
            end
            assign rd_final = pipe[RD_LAT-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            last_d       <= 1'b0;
            gnt_d        <= 1'b0;
            lat_cnt      <= '0;
            ram_addr     <= '0;
            ram_ok       <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
            cnt_if       <= '0;
            cnt_d        <= '0;
            dbg_rdata    <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                gnt_d    <= take_d;
                last_d   <= take_d;
                ram_addr <= sel_addr;
                ram_ok   <= in_range(sel_addr);
                lat_cnt  <= '0;
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            if (state == S_WAIT && state_n == S_ACK) begin
                if (gnt_d) bus.d_rdata  <= rd_final;
                else       bus.if_rdata <= rd_final;
            end
            if (state == S_ACK) begin
                if (gnt_d) begin
                    if (cnt_d != 16'hFFFF) cnt_d <= cnt_d + 16'd1;
                end else begin
                    if (cnt_if != 16'hFFFF) cnt_if <= cnt_if + 16'd1;
                end
            end
            // Sampled alongside the write edge, so same-address writes show next cycle.
            dbg_rdata <= in_range(dbg_addr) ? mem[dbg_addr] : '0;
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed self-checking bench for mem_arb
module tb_mem_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  dbg_addr0, dbg_addr1;
    logic [31:0] dbg_rdata0, dbg_rdata1;
    logic        busy0, busy1;
    logic [15:0] cnt_if0, cnt_d0, cnt_if1, cnt_d1;

    mem_arb_if #(.AW(8), .DW(32)) b0 ();
    mem_arb_if #(.AW(8), .DW(32)) b1 ();

    mem_arb #(.AW(8), .DW(32), .DEPTH(256), .RD_LAT(1)) u0 (
        .clk(clk), .rst(rst), .bus(b0), .dbg_addr(dbg_addr0), .dbg_rdata(dbg_rdata0),
        .busy(busy0), .cnt_if(cnt_if0), .cnt_d(cnt_d0)
    );

    mem_arb #(.AW(8), .DW(32), .DEPTH(200), .RD_LAT(3)) u1 (
        .clk(clk), .rst(rst), .bus(b1), .dbg_addr(dbg_addr1), .dbg_rdata(dbg_rdata1),
        .busy(busy1), .cnt_if(cnt_if1), .cnt_d(cnt_d1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_txn(input int u, input logic we, input logic [3:0] be, input logic [7:0] a,
                         input logic [31:0] wd, input int exp_lat, input string tag);
        int   n;
        logic ack;
        n   = 0;
        ack = 1'b0;
        if (u == 0) begin
            b0.d_we = we; b0.d_be = be; b0.d_addr = a; b0.d_wdata = wd; b0.d_req = 1'b1;
        end else begin
            b1.d_we = we; b1.d_be = be; b1.d_addr = a; b1.d_wdata = wd; b1.d_req = 1'b1;
        end
        while (!ack && n < 20) begin
            tick();
            n++;
            ack = (u == 0) ? b0.d_ack : b1.d_ack;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        if (u == 0) b0.d_req = 1'b0;
        else        b1.d_req = 1'b0;
        tick();
    endtask

    task automatic if_txn(input int u, input logic [7:0] a, input int exp_lat, input string tag);
        int   n;
        logic ack;
        n   = 0;
        ack = 1'b0;
        if (u == 0) begin b0.if_addr = a; b0.if_req = 1'b1; end
        else        begin b1.if_addr = a; b1.if_req = 1'b1; end
        while (!ack && n < 20) begin
            tick();
            n++;
            ack = (u == 0) ? b0.if_ack : b1.if_ack;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        if (u == 0) b0.if_req = 1'b0;
        else        b1.if_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacks;
        int cyc;
        rst = 1'b1;
        b0.if_req = 0; b0.if_addr = 0; b0.d_req = 0; b0.d_we = 0; b0.d_be = 0; b0.d_addr = 0; b0.d_wdata = 0;
        b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_be = 0; b1.d_addr = 0; b1.d_wdata = 0;
        dbg_addr0 = 0;
        dbg_addr1 = 0;
        tick();
        tick();

        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_if_ack", 32'(b0.if_ack), 0);
        chk("rst_d_ack", 32'(b0.d_ack), 0);
        chk("rst_if_rdata", b0.if_rdata, 0);
        chk("rst_d_rdata", b0.d_rdata, 0);
        chk("rst_dbg", dbg_rdata0, 0);
        chk("rst_cnt_if", 32'(cnt_if0), 0);
        chk("rst_cnt_d", 32'(cnt_d0), 0);
        rst = 1'b0;
        tick();

        d_txn(0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1, "wr10");
        if_txn(0, 8'h10, 2, "if10");
        chk("if10_data", b0.if_rdata, 32'hDEADBEEF);
        chk("cnt_if_1", 32'(cnt_if0), 1);
        chk("cnt_d_1", 32'(cnt_d0), 1);

        d_txn(0, 1'b1, 4'hF, 8'd5, 32'h11223344, 1, "wr5a");
        d_txn(0, 1'b1, 4'b0101, 8'd5, 32'hAABBCCDD, 1, "wr5b");
        d_txn(0, 1'b0, 4'h0, 8'd5, 32'h0, 2, "rd5");
        chk("rd5_data", b0.d_rdata, 32'h11BB33DD);
        d_txn(0, 1'b1, 4'h0, 8'd5, 32'hFFFFFFFF, 1, "wr5_be0");
        dbg_addr0 = 8'd5;
        tick();
        chk("be0_nochange", dbg_rdata0, 32'h11BB33DD);
        chk("cnt_d_5", 32'(cnt_d0), 5);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("arb_rst_cnt_d", 32'(cnt_d0), 0);
        b0.if_addr = 8'h10;
        b0.d_addr  = 8'd5;
        b0.d_we    = 1'b0;
        b0.if_req  = 1'b1;
        b0.d_req   = 1'b1;
        nacks = 0;
        cyc   = 0;
        while (nacks < 4 && cyc < 40) begin
            tick();
            cyc++;
            chk("ack_overlap", 32'(b0.if_ack & b0.d_ack), 0);
            if (b0.if_ack || b0.d_ack) begin
                chk($sformatf("arb%0d_cycle", nacks), 32'(cyc), 32'(2 + 3 * nacks));
                chk($sformatf("arb%0d_is_data", nacks), 32'(b0.d_ack), (nacks % 2 == 0) ? 1 : 0);
                if (b0.d_ack) chk("arb_d_data", b0.d_rdata, 32'h11BB33DD);
                else          chk("arb_if_data", b0.if_rdata, 32'hDEADBEEF);
                nacks++;
            end
        end
        chk("arb_nacks", 32'(nacks), 4);
        b0.if_req = 1'b0;
        b0.d_req  = 1'b0;
        tick();
        chk("arb_cnt_if", 32'(cnt_if0), 2);
        chk("arb_cnt_d", 32'(cnt_d0), 2);

        d_txn(1, 1'b1, 4'hF, 8'd150, 32'hCAFEF00D, 1, "u1_wr150");
        d_txn(1, 1'b0, 4'h0, 8'd150, 32'h0, 4, "u1_rd150");
        chk("u1_rd150_data", b1.d_rdata, 32'hCAFEF00D);
        if_txn(1, 8'd150, 4, "u1_if150");
        chk("u1_if150_data", b1.if_rdata, 32'hCAFEF00D);
        d_txn(1, 1'b0, 4'h0, 8'd250, 32'h0, 4, "u1_rd250");
        chk("u1_rd250_data", b1.d_rdata, 0);
        d_txn(1, 1'b1, 4'hF, 8'd250, 32'h12345678, 1, "u1_wr250");
        dbg_addr1 = 8'd250;
        tick();
        chk("u1_dbg250", dbg_rdata1, 0);
        dbg_addr1 = 8'd150;
        tick();
        chk("u1_dbg150", dbg_rdata1, 32'hCAFEF00D);
        chk("u1_cnt_if", 32'(cnt_if1), 1);
        chk("u1_cnt_d", 32'(cnt_d1), 4);

        b0.d_addr = 8'd5;
        b0.d_we   = 1'b0;
        b0.d_req  = 1'b1;
        tick();
        chk("mid_busy_wait", 32'(busy0), 1);
        rst = 1'b1;
        b0.d_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid_busy0", 32'(busy0), 0);
        chk("mid_no_ack", 32'(b0.d_ack), 0);
        chk("mid_cnt_d", 32'(cnt_d0), 0);
        chk("mid_cnt_if", 32'(cnt_if0), 0);

        b0.d_we = 1'b1; b0.d_be = 4'hF; b0.d_addr = 8'h10; b0.d_wdata = 32'h0;
        b0.d_req = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b0.d_req = 1'b0;
        dbg_addr0 = 8'h10;
        tick();
        chk("rst_wr_blocked", dbg_rdata0, 32'hDEADBEEF);
        chk("rst_wr_no_ack", 32'(b0.d_ack), 0);

        dbg_addr0 = 8'd5;
        tick();
        b0.d_we = 1'b1; b0.d_be = 4'hF; b0.d_addr = 8'd5; b0.d_wdata = 32'h0BADC0DE;
        b0.d_req = 1'b1;
        tick();
        chk("rdw_old", dbg_rdata0, 32'h11BB33DD);
        chk("rdw_ack", 32'(b0.d_ack), 1);
        b0.d_req = 1'b0;
        tick();
        chk("rdw_new", dbg_rdata0, 32'h0BADC0DE);

        force u0.cnt_d = 16'hFFFE;
        tick();
        release u0.cnt_d;
        d_txn(0, 1'b1, 4'hF, 8'd7, 32'h1, 1, "sat_a");
        chk("sat_ffff", 32'(cnt_d0), 32'h0000FFFF);
        d_txn(0, 1'b1, 4'hF, 8'd7, 32'h2, 1, "sat_b");
        chk("sat_hold", 32'(cnt_d0), 32'h0000FFFF);
        chk("sat_cnt_if", 32'(cnt_if0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
# mem_arb

Unified single-port memory with a two-requester arbiter: one instruction-fetch port and one data load/store port share one synchronous RAM through a req/ack handshake. It replaces separate fixed 8-bit-address instruction and data memories under the multicycle CPU. Address width, data width, depth and read latency are parametrised. It adds byte-enable writes, round-robin arbitration, a registered debug read port and transaction counters.

## Interface
- AW, 8, address width (word addresses)
- DW, 32, data width; multiple of 8
- DEPTH, 256, words implemented; must be ≤ 2**AW
- RD_LAT, 1, RAM read pipeline depth in cycles; legal range 1..4
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  AW  fetch address; stable while if_req is high
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  DW  fetch data; valid in the if_ack cycle, held until the next if_ack
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req is high
- d_be  in  DW/8  byte enables for writes; bit i covers byte i
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  DW  read data; valid in the d_ack cycle, held until the next d_ack
- dbg_addr  in  AW  debug read address
- dbg_rdata  out  DW  debug read data
- busy  out  1  high when state is not IDLE
- cnt_if  out  16  completed fetch count
- cnt_d  out  16  completed data-access count

## Operation
- FSM states:
  - IDLE: sample the requests.
  - WAIT: count read latency.
  - ACK: pulse ack for one cycle, then return to IDLE.
- In IDLE, with a request pending, latch the winner, its address and its write/read type.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester not granted last wins.
  - The last-grant register resets to "fetch", so the first tie after reset goes to data.
- Data write, granted at edge E:
  - At edge E, RAM bytes with d_be[i]=1 take d_wdata.
  - Next state is ACK; RD_LAT does not apply to writes.
  - d_be = 0 completes normally with no change to memory.
- Read:
  - The RAM address is registered at the grant edge.
  - The FSM stays in WAIT for RD_LAT cycles, then enters ACK.
  - The rdata register for the winning port is loaded on the edge that enters ACK.
- ACK: requests are not sampled. The requester drops req, or starts a new request, on the edge that ends ACK.
- Address ≥ DEPTH: reads return 0; writes are ignored. Ack timing is unchanged.
- Debug port:
  - Independent; dbg_rdata is registered with 1-cycle latency, every cycle.
  - Read-during-write to the same address returns the old data.
  - Out-of-range addresses return 0.
- Counters: cnt_if / cnt_d increment on each respective ack and saturate at 16'hFFFF.
- Memory contents are not initialised and are not cleared by rst.

## Timing
- Reset values:
  - State IDLE; last grant = fetch.
  - if_ack = 0, d_ack = 0, busy = 0.
  - if_rdata = 0, d_rdata = 0, dbg_rdata = 0.
  - cnt_if = 0, cnt_d = 0.
- Taking cycle N as the cycle in which req is sampled high in IDLE:
  - Read ack is high in cycle N+1+RD_LAT.
  - Write ack is high in cycle N+1.
- Throughput:
  - Back-to-back reads from one port: one transaction per RD_LAT+2 cycles.
  - Back-to-back writes from one port: one per 2 cycles.
- A request arriving during WAIT or ACK is held by the requester and is considered in the next IDLE cycle.
- rst has priority over everything:
  - A write whose grant edge coincides with rst high is not performed.
  - A transaction in progress is aborted with no ack.
  - Writes already committed remain in memory.
- if_ack and d_ack are never high in the same cycle.

## Test plan
- RD_LAT=1: d_req write of 32'hDEADBEEF to addr 8'h10, d_be=4'hF → d_ack in N+1. Then if_req to addr 8'h10 → if_ack in N+2 with if_rdata=32'hDEADBEEF.
- Byte enables: write 32'h11223344 to addr 5, then write 32'hAABBCCDD with d_be=4'b0101, then read addr 5 → d_rdata=32'h11BB33DD.
- Arbitration with both req held high for 4 transactions → grant order data, fetch, data, fetch. cnt_if=2, cnt_d=2. Acks never overlap.
- RD_LAT=3, DEPTH=200, AW=8:
  - Read addr 150 → ack 4 cycles after request, with stored data.
  - Read addr 250 → rdata=0.
  - Write to addr 250, then debug read of addr 250 → 0.
- Reset mid-transaction: assert rst during WAIT → no ack, busy=0 next cycle, counters 0. Memory contents written before the reset are still readable via dbg_addr after 1 cycle.
- Debug read-during-write to the same address → old value first cycle, new value next cycle. Counter held at 16'hFFFF does not wrap.
